// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//
// Front end for the 4-bit adder demo board. The seven raw push-buttons pass
// through an optional two-flop synchronizer. Each one is then debounced by its
// own counter. A debounced level only changes after the sampled input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clock edges. Each
// debounced edge produces a one-cycle press or release pulse. Buttons
// {2,5,4,6} form the adder b-operand. Any change of an operand bit raises a
// single one-cycle operand_valid strobe.
//
// Build option:
//   BUTTON_DEBOUNCE_SYNC_EN  defined   -> two-flop synchronizer in front of the
//                                         debouncers. Raw edge to btn_stable
//                                         latency is DEBOUNCE_CYCLES+2 edges.
//                            undefined -> BUTTON feeds the debouncers directly.
//                                         Latency is DEBOUNCE_CYCLES edges.
//                                         Use this build only with stimulus
//                                         that is already synchronous to clk.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing edges needed to flip (2..65535)
//   CNT_W            per-button counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst_n          synchronous reset, active-low
//   BUTTON[6:0]    raw asynchronous bouncing button levels, 1 = pressed
//   btn_stable     debounced button levels
//   btn_press      one-cycle pulse on each debounced 0->1 transition
//   btn_release    one-cycle pulse on each debounced 1->0 transition
//   operand[3:0]   {btn_stable[2], btn_stable[5], btn_stable[4], btn_stable[6]}
//   operand_valid  one-cycle pulse whenever any operand bit changes
// ----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] BUTTON,
    output logic [6:0] btn_stable,
    output logic [6:0] btn_press,
    output logic [6:0] btn_release,
    output logic [3:0] operand,
    output logic       operand_valid
);

    localparam int              NBTN     = 7;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Buttons that feed the adder operand: bits 6, 5, 4 and 2.
    localparam logic [NBTN-1:0] OPERAND_MASK = 7'b1110100;

    // Next count for one channel. The count restarts on agreement and also
    // on the edge that flips the debounced level, so it never passes CNT_LAST.
    function automatic logic [CNT_W-1:0] cnt_advance(
        input logic [CNT_W-1:0] cur,
        input logic             differ
    );
        if (!differ || (cur == CNT_LAST)) begin
            return '0;
        end
        return cur + CNT_W'(1);
    endfunction

    // A channel flips on its DEBOUNCE_CYCLES-th consecutive disagreeing edge.
    function automatic logic cnt_expired(
        input logic [CNT_W-1:0] cur,
        input logic             differ
    );
        return differ && (cur == CNT_LAST);
    endfunction

    logic [NBTN-1:0]  samp;
    logic [NBTN-1:0]  differ;
    logic [NBTN-1:0]  flip;
    logic [CNT_W-1:0] cnt      [NBTN];
    logic [CNT_W-1:0] cnt_next [NBTN];

    // ---- stage p0/p1: metastability synchronizer --------------------------
`ifdef BUTTON_DEBOUNCE_SYNC_EN
    logic [NBTN-1:0] sync_p0;
    logic [NBTN-1:0] sync_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= BUTTON;
            sync_p1 <= sync_p0;
        end
    end

    assign samp = sync_p1;
`else
    assign samp = BUTTON;
`endif

    // ---- stage p2: per-button debounce counters ---------------------------
    assign differ = samp ^ btn_stable;

    always_comb begin
        flip = '0;
        for (int i = 0; i < NBTN; i++) begin
            cnt_next[i] = cnt_advance(cnt[i], differ[i]);
            flip[i]     = cnt_expired(cnt[i], differ[i]);
        end
    end

    // A flip always moves btn_stable to the sampled level. So samp tells
    // whether the flip is a press or a release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
            btn_stable    <= '0;
            btn_press     <= '0;
            btn_release   <= '0;
            operand_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= cnt_next[i];
            end
            btn_stable    <= btn_stable ^ flip;
            btn_press     <= flip & samp;
            btn_release   <= flip & ~samp;
            operand_valid <= |(flip & OPERAND_MASK);
        end
    end

    assign operand = {btn_stable[2], btn_stable[5], btn_stable[4], btn_stable[6]};

endmodule

// File: tb/tb_button_debounce.sv
// ----------------------------------------------------------------------------
// tb_button_debounce
//
// Bench for button_debounce with DEBOUNCE_CYCLES = 4. The expected latency
// follows the BUTTON_DEBOUNCE_SYNC_EN build option.
// A reference model runs alongside the DUT for the whole run. It keeps the
// history of sampled button levels. A channel flips once its last
// DEBOUNCE_CYCLES samples, all taken after its previous flip or reset, have
// all disagreed with the debounced level.
// ----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int D = 4;
`ifdef BUTTON_DEBOUNCE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = D + SYNC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] BUTTON;
    logic [6:0] btn_stable;
    logic [6:0] btn_press;
    logic [6:0] btn_release;
    logic [3:0] operand;
    logic       operand_valid;

    int n_pass  = 0;
    int n_total = 0;

    button_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .BUTTON        (BUTTON),
        .btn_stable    (btn_stable),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .operand       (operand),
        .operand_valid (operand_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [6:0] bhist[$];      // earlier BUTTON samples, newest first
    logic [6:0] seen_hist[$];  // levels seen by the debouncers, newest first
    int         edge_n = 0;
    int         last_flip[7];
    logic [6:0] m_stable, m_press, m_rel;
    logic       m_opv;
    bit         model_ready = 0;

    always @(posedge clk) begin
        logic [6:0] seen;
        logic [6:0] flips;
        bit         all_diff;
        edge_n++;
        seen = (SYNC == 0) ? BUTTON : bhist[(SYNC > 0) ? SYNC - 1 : 0];
        if (!rst_n) begin
            bhist.delete();
            for (int k = 0; k < SYNC; k++) bhist.push_back(7'b0);
            seen_hist.delete();
            for (int i = 0; i < 7; i++) last_flip[i] = edge_n;
            m_stable = '0; m_press = '0; m_rel = '0; m_opv = 1'b0;
            model_ready = 1;
        end else begin
            bhist.push_front(BUTTON);
            if (bhist.size() > SYNC) void'(bhist.pop_back());
            seen_hist.push_front(seen);
            if (seen_hist.size() > D) void'(seen_hist.pop_back());
            flips = '0;
            for (int i = 0; i < 7; i++) begin
                if (edge_n - last_flip[i] >= D) begin
                    all_diff = 1;
                    for (int k = 0; k < D; k++)
                        if (seen_hist[k][i] == m_stable[i]) all_diff = 0;
                    if (all_diff) begin
                        flips[i] = 1'b1;
                        last_flip[i] = edge_n;
                    end
                end
            end
            m_stable = m_stable ^ flips;
            m_press  = flips & m_stable;
            m_rel    = flips & ~m_stable;
            m_opv    = flips[2] | flips[4] | flips[5] | flips[6];
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            chk("model_stable",  btn_stable,  m_stable);
            chk("model_press",   btn_press,   m_press);
            chk("model_release", btn_release, m_rel);
            chk("model_operand", {3'b0, operand},
                {3'b0, m_stable[2], m_stable[5], m_stable[4], m_stable[6]});
            chk("model_opvalid", {6'b0, operand_valid}, {6'b0, m_opv});
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        string      name;
        logic       rst_n;
        logic [6:0] button;
        int         ncyc;
        logic [6:0] stable;
        logic [6:0] press;
        logic [6:0] rel;
        logic [3:0] op;
        logic       opv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic r, logic [6:0] b, int n,
                                logic [6:0] s, logic [6:0] p, logic [6:0] rl,
                                logic [3:0] o, logic ov);
        vec_t v;
        v.name = nm; v.rst_n = r; v.button = b; v.ncyc = n;
        v.stable = s; v.press = p; v.rel = rl; v.op = o; v.opv = ov;
        return v;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_vec(input vec_t v);
        chk({v.name, "_stable"},  btn_stable,  v.stable);
        chk({v.name, "_press"},   btn_press,   v.press);
        chk({v.name, "_release"}, btn_release, v.rel);
        chk({v.name, "_operand"}, {3'b0, operand}, {3'b0, v.op});
        chk({v.name, "_opvalid"}, {6'b0, operand_valid}, {6'b0, v.opv});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst_n  = 1'b0;
        BUTTON = 7'b0;

        tbl.push_back(mk("reset",       0, 7'h00, 2,     7'h00, 7'h00, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("idle",        1, 7'h00, 20,    7'h00, 7'h00, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("b6_pre",      1, 7'h40, LAT-1, 7'h00, 7'h00, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("b6_press",    1, 7'h40, 1,     7'h40, 7'h40, 7'h00, 4'b0001, 1));
        tbl.push_back(mk("b6_hold",     1, 7'h40, 1,     7'h40, 7'h00, 7'h00, 4'b0001, 0));
        tbl.push_back(mk("b6_rel_pre",  1, 7'h00, LAT-1, 7'h40, 7'h00, 7'h00, 4'b0001, 0));
        tbl.push_back(mk("b6_release",  1, 7'h00, 1,     7'h00, 7'h00, 7'h40, 4'b0000, 1));
        tbl.push_back(mk("b6_idle",     1, 7'h00, 1,     7'h00, 7'h00, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("multi_pre",   1, 7'h34, LAT-1, 7'h00, 7'h00, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("multi_press", 1, 7'h34, 1,     7'h34, 7'h34, 7'h00, 4'b1110, 1));
        tbl.push_back(mk("multi_hold",  1, 7'h34, 3,     7'h34, 7'h00, 7'h00, 4'b1110, 0));
        tbl.push_back(mk("multi_rpre",  1, 7'h00, LAT-1, 7'h34, 7'h00, 7'h00, 4'b1110, 0));
        tbl.push_back(mk("multi_rel",   1, 7'h00, 1,     7'h00, 7'h00, 7'h34, 4'b0000, 1));
        tbl.push_back(mk("multi_idle",  1, 7'h00, 1,     7'h00, 7'h00, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("b0_pre",      1, 7'h01, LAT-1, 7'h00, 7'h00, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("b0_press",    1, 7'h01, 1,     7'h01, 7'h01, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("b0_hold",     1, 7'h01, 2,     7'h01, 7'h00, 7'h00, 4'b0000, 0));
        tbl.push_back(mk("b0_release",  1, 7'h00, LAT,   7'h00, 7'h00, 7'h01, 4'b0000, 0));
        tbl.push_back(mk("b0_idle",     1, 7'h00, 2,     7'h00, 7'h00, 7'h00, 4'b0000, 0));

        foreach (tbl[k]) begin
            rst_n  = tbl[k].rst_n;
            BUTTON = tbl[k].button;
            wait_cycles(tbl[k].ncyc);
            check_vec(tbl[k]);
        end

        // Bounce on bit 4: alternating samples never build a run.
        for (int c = 0; c < 10; c++) begin
            BUTTON = (c % 2 == 0) ? 7'h10 : 7'h00;
            wait_cycles(1);
            chk("bounce_stable", btn_stable, 7'h00);
            chk("bounce_press",  btn_press,  7'h00);
        end
        BUTTON = 7'h00;
        wait_cycles(LAT);
        chk("bounce_settle", btn_stable, 7'h00);

        // A pulse one cycle shorter than the debounce window is rejected.
        BUTTON = 7'h10;
        wait_cycles(D - 1);
        BUTTON = 7'h00;
        wait_cycles(LAT + 2);
        chk("short_stable",  btn_stable, 7'h00);
        chk("short_operand", {3'b0, operand}, 7'h00);

        // Reset while bit 2 is mid-count. After release the button debounces
        // again from zero.
        BUTTON = 7'h04;
        wait_cycles(SYNC + 2);
        rst_n = 1'b0;
        wait_cycles(1);
        chk("rstmid_stable", btn_stable, 7'h00);
        rst_n = 1'b1;
        wait_cycles(1);
        chk("rstrel_press",  btn_press,  7'h00);
        wait_cycles(LAT - 2);
        chk("rstrel_pre_stable", btn_stable, 7'h00);
        chk("rstrel_pre_press",  btn_press,  7'h00);
        wait_cycles(1);
        chk("rstrel_press_bit2", btn_press, 7'h04);
        chk("rstrel_opvalid", {6'b0, operand_valid}, 7'h01);
        chk("rstrel_operand", {3'b0, operand}, 7'b0001000);
        BUTTON = 7'h00;
        wait_cycles(LAT + 2);

        // Random stimulus, checked each cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            case ($urandom_range(0, 15))
                0, 1, 2: begin
                    idx = $urandom_range(0, 6);
                    BUTTON[idx] = ~BUTTON[idx];
                end
                3: BUTTON = 7'($urandom);
                default: ;
            endcase
            wait_cycles(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
